// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM register and a word-wide DataMemory.
// Handles big-endian sub-word loads directly and sub-word stores with a read-modify-write.
module mem_access_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  output logic [31:0] DmAddress,
  output logic [31:0] DmWriteData,
  output logic        DmMemWrite,
  output logic        DmMemRead,
  input  logic [31:0] DmReadData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MisalignErr,
  output logic [31:0] ErrAddress
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t      state, stateNext;
  logic [31:0] mergeWord, mergeAddr;
  logic [15:0] mergeData;
  logic [1:0]  mergeOff, mergeSize;

  logic        isHalf, isByte, misaligned, access;
  logic        latchMerge, flagErr;
  logic [31:0] loadVal;

  assign isHalf     = (Size == 2'b01);
  assign isByte     = (Size == 2'b10);
  assign access     = MemWrite | MemRead;
  // Size 11 falls through to the word rule
  assign misaligned = isByte ? 1'b0 : (isHalf ? Address[0] : (Address[1:0] != 2'b00));

  // Replace the addressed big-endian lane(s) of the latched word
  function automatic logic [31:0] mergeLane(input logic [31:0] w, input logic [15:0] d,
                                            input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    if (sz == 2'b10) begin
      case (off)
        2'd0: r = {d[7:0], w[23:0]};
        2'd1: r = {w[31:24], d[7:0], w[15:0]};
        2'd2: r = {w[31:16], d[7:0], w[7:0]};
        2'd3: r = {w[31:8], d[7:0]};
      endcase
    end else begin
      r = off[1] ? {w[31:16], d} : {d, w[15:0]};
    end
    return r;
  endfunction

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    loadVal = DmReadData;
    case (Address[1:0])
      2'd0:    b = DmReadData[31:24];
      2'd1:    b = DmReadData[23:16];
      2'd2:    b = DmReadData[15:8];
      default: b = DmReadData[7:0];
    endcase
    h = Address[1] ? DmReadData[15:0] : DmReadData[31:16];
    if (isByte)
      loadVal = {{24{SignExt & b[7]}}, b};
    else if (isHalf)
      loadVal = {{16{SignExt & h[15]}}, h};
  end

  always_comb begin
    stateNext   = state;
    DmAddress   = {Address[31:2], 2'b00};
    DmWriteData = WriteData;
    DmMemWrite  = 1'b0;
    DmMemRead   = 1'b0;
    ReadData    = 32'h0;
    Stall       = 1'b0;
    latchMerge  = 1'b0;
    flagErr     = 1'b0;
    // Reset gates every strobe, which also drops a pending merge write
    if (!Rst) begin
      case (state)
        IDLE: begin
          if (access && misaligned) begin
            flagErr = 1'b1;
          end else if (MemWrite) begin
            if (isHalf || isByte) begin
              DmMemRead  = 1'b1;
              Stall      = 1'b1;
              latchMerge = 1'b1;
              stateNext  = MERGE;
            end else begin
              DmMemWrite = 1'b1;
            end
          end else if (MemRead) begin
            DmMemRead = 1'b1;
            ReadData  = loadVal;
          end
        end
        MERGE: begin
          DmAddress   = mergeAddr;
          DmWriteData = mergeLane(mergeWord, mergeData, mergeOff, mergeSize);
          DmMemWrite  = 1'b1;
          stateNext   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      mergeWord   <= 32'h0;
      mergeAddr   <= 32'h0;
      mergeData   <= 16'h0;
      mergeOff    <= 2'b00;
      mergeSize   <= 2'b00;
      MisalignErr <= 1'b0;
      ErrAddress  <= 32'h0;
    end else begin
      state <= stateNext;
      if (latchMerge) begin
        mergeWord <= DmReadData;
        mergeAddr <= {Address[31:2], 2'b00};
        mergeData <= WriteData[15:0];
        mergeOff  <= Address[1:0];
        mergeSize <= Size;
      end
      if (flagErr) begin
        MisalignErr <= 1'b1;
        if (!MisalignErr) ErrAddress <= Address;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory and a write scoreboard.
module tb_mem_access_unit;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] Address = '0, WriteData = '0;
  logic        MemWrite = 1'b0, MemRead = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        SignExt = 1'b0;
  logic [31:0] DmAddress, DmWriteData, DmReadData, ReadData, ErrAddress;
  logic        DmMemWrite, DmMemRead, Stall, MisalignErr;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t expWr[$];

  logic [31:0] mem [0:15];

  mem_access_unit dut (
    .Clk(Clk), .Rst(Rst), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .Size(Size), .SignExt(SignExt),
    .DmAddress(DmAddress), .DmWriteData(DmWriteData), .DmMemWrite(DmMemWrite),
    .DmMemRead(DmMemRead), .DmReadData(DmReadData), .ReadData(ReadData),
    .Stall(Stall), .MisalignErr(MisalignErr), .ErrAddress(ErrAddress)
  );

  always #5 Clk = ~Clk;

  // Data memory: combinational read (0 when not reading), write on rising edge
  assign DmReadData = (DmMemRead === 1'b1) ? mem[DmAddress[5:2]] : 32'h0;
  always @(posedge Clk)
    if (DmMemWrite === 1'b1) mem[DmAddress[5:2]] <= DmWriteData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next expected write
  always @(negedge Clk) begin
    if (DmMemWrite === 1'b1) begin
      if (expWr.size() == 0) begin
        check("unexpectedWrite", {31'b0, DmMemWrite}, 32'h0);
      end else begin
        wr_t e;
        e = expWr.pop_front();
        check("wrAddr", DmAddress, e.addr);
        check("wrData", DmWriteData, e.data);
      end
    end
  end

  task automatic drive(input logic mw, input logic mr, input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] wd);
    @(posedge Clk); #1;
    MemWrite = mw; MemRead = mr; Size = sz; SignExt = se; Address = a; WriteData = wd;
    @(negedge Clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h1122_3344;
    mem[3] = 32'h8001_7FFF;
    mem[0] = 32'h0102_0304;

    // Reset values
    idle(); idle();
    check("rstStall", {31'b0, Stall}, 32'h0);
    check("rstWr", {31'b0, DmMemWrite}, 32'h0);
    check("rstRd", {31'b0, DmMemRead}, 32'h0);
    check("rstReadData", ReadData, 32'h0);
    check("rstErr", {31'b0, MisalignErr}, 32'h0);
    check("rstErrAddr", ErrAddress, 32'h0);
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk);

    // Word store then word load
    expWr.push_back('{32'h8, 32'hDEAD_BEEF});
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h8, 32'hDEAD_BEEF);
    check("swStall", {31'b0, Stall}, 32'h0);
    check("swWr", {31'b0, DmMemWrite}, 32'h1);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h8, 32'h0);
    check("lwData", ReadData, 32'hDEAD_BEEF);
    check("lwRd", {31'b0, DmMemRead}, 32'h1);
    check("lwStall", {31'b0, Stall}, 32'h0);
    idle();
    check("noLoadReadData", ReadData, 32'h0);

    // Byte store merge at offset 2
    expWr.push_back('{32'h4, 32'h1122_AA44});
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0000_00AA);
    check("sbStall", {31'b0, Stall}, 32'h1);
    check("sbRd", {31'b0, DmMemRead}, 32'h1);
    check("sbNoWr", {31'b0, DmMemWrite}, 32'h0);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0000_00AA);
    check("sbMergeStall", {31'b0, Stall}, 32'h0);
    check("sbMergeWr", {31'b0, DmMemWrite}, 32'h1);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h6, 32'h0);
    check("lbuData", ReadData, 32'h0000_00AA);

    // Halfword store merge into the low half of the same word
    expWr.push_back('{32'h4, 32'h1122_BEEF});
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h1234_BEEF);
    check("shStall", {31'b0, Stall}, 32'h1);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h1234_BEEF);
    idle();
    check("shMem", mem[1], 32'h1122_BEEF);

    // Load extension
    drive(1'b0, 1'b1, 2'b01, 1'b1, 32'hC, 32'h0);
    check("lhSigned", ReadData, 32'hFFFF_8001);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'hE, 32'h0);
    check("lhuLow", ReadData, 32'h0000_7FFF);
    drive(1'b0, 1'b1, 2'b10, 1'b1, 32'hC, 32'h0);
    check("lbSigned", ReadData, 32'hFFFF_FF80);
    drive(1'b0, 1'b1, 2'b11, 1'b0, 32'hC, 32'h0);
    check("lwReservedSize", ReadData, 32'h8001_7FFF);

    // Simultaneous store and load: store wins
    expWr.push_back('{32'h10, 32'h5});
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h5);
    check("bothRd", {31'b0, DmMemRead}, 32'h0);
    check("bothReadData", ReadData, 32'h0);
    check("bothWr", {31'b0, DmMemWrite}, 32'h1);

    // Misalignment: first address sticks
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h6, 32'h0);
    check("misLwRd", {31'b0, DmMemRead}, 32'h0);
    check("misLwWr", {31'b0, DmMemWrite}, 32'h0);
    check("misLwReadData", ReadData, 32'h0);
    check("misLwStall", {31'b0, Stall}, 32'h0);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h9, 32'h1234);
    check("misShRd", {31'b0, DmMemRead}, 32'h0);
    check("misShStall", {31'b0, Stall}, 32'h0);
    check("misErrSet", {31'b0, MisalignErr}, 32'h1);
    idle();
    check("misErrSticky", {31'b0, MisalignErr}, 32'h1);
    check("misErrAddr", ErrAddress, 32'h6);

    // Reset during MERGE drops the write
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0055);
    check("rmStall", {31'b0, Stall}, 32'h1);
    @(posedge Clk); #1 Rst = 1'b1;
    @(negedge Clk);
    check("rmNoWr", {31'b0, DmMemWrite}, 32'h0);
    check("rmStallLow", {31'b0, Stall}, 32'h0);
    @(negedge Clk);
    check("rmErrClr", {31'b0, MisalignErr}, 32'h0);
    check("rmErrAddrClr", ErrAddress, 32'h0);
    check("rmReadData", ReadData, 32'h0);
    @(posedge Clk); #1;
    Rst = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; Address = 32'h0;
    @(negedge Clk);
    check("rmIdleWr", {31'b0, DmMemWrite}, 32'h0);
    check("rmMemKept", mem[0], 32'h0102_0304);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
    check("rmLoadAfter", ReadData, 32'h0102_0304);
    check("rmLoadStall", {31'b0, Stall}, 32'h0);
    idle(); idle();

    check("pendingWrites", expWr.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
